// File: rtl/booth_pp_acc_if.sv
// Handshake and data bundle between the Booth partial-product generator / execute
// stage (master) and the partial-product accumulator (slave).
interface booth_pp_acc_if #(
  parameter int LENGTH = 32,
  parameter int NUM_PP = LENGTH / 2
);
  logic                           flush_i;
  logic                           in_valid_i;
  logic                           in_ready_o;
  logic [NUM_PP*(LENGTH+1)-1:0]   pp_flat_i;
  logic                           sel_high_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [2*LENGTH-1:0]            product_o;
  logic [LENGTH-1:0]              result_o;

  modport master (
    output flush_i, in_valid_i, pp_flat_i, sel_high_i, out_ready_i,
    input  in_ready_o, out_valid_o, product_o, result_o
  );

  modport slave (
    input  flush_i, in_valid_i, pp_flat_i, sel_high_i, out_ready_i,
    output in_ready_o, out_valid_o, product_o, result_o
  );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Multi-cycle reduction of radix-4 Booth partial products into a signed 2*LENGTH product.
// Optional macro BOOTH_ACC_EARLY_DONE_EN: finish early once all remaining groups are zero.
module booth_pp_accumulator #(
  parameter int LENGTH = 32,
  parameter int NUM_PP = LENGTH / 2,
  parameter int PPC    = 4
) (
  input  logic                clk,
  input  logic                rst,
  booth_pp_acc_if.slave       bus
);

  localparam int N     = NUM_PP / PPC;
  localparam int GRP_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
  localparam int PP_W  = LENGTH + 1;
  localparam int ACC_W = 2 * LENGTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]              state;
  logic [GRP_W-1:0]        grp;
  logic signed [PP_W-1:0]  pp_p0 [NUM_PP];
  logic                    sel_high_p0;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] grp_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic [IDX_W-1:0]        idx;
  logic [ACC_W-1:0]        product_r;
  logic [LENGTH-1:0]       result_r;
  logic                    last_grp;

  // Partial k carries weight 4^k: sign-extend to full width, then shift by 2k.
  function automatic logic signed [ACC_W-1:0] weight_pp(
    input logic signed [PP_W-1:0] pp,
    input logic [IDX_W-1:0]       k
  );
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
    return ext << {k, 1'b0};
  endfunction

  always_comb begin
    grp_sum = '0;
    idx     = '0;
    for (int j = 0; j < PPC; j++) begin
      idx     = IDX_W'(int'(grp) * PPC + j);
      grp_sum = grp_sum + weight_pp(pp_p0[idx], idx);
    end
    acc_next = acc + grp_sum;
  end

`ifdef BOOTH_ACC_EARLY_DONE_EN
  logic [N-1:0] grp_nz;
  logic         rest_zero;

  always_comb begin
    grp_nz = '0;
    for (int g = 0; g < N; g++) begin
      for (int j = 0; j < PPC; j++) begin
        if (pp_p0[g*PPC+j] != '0) grp_nz[g] = 1'b1;
      end
    end
    rest_zero = 1'b1;
    for (int g = 0; g < N; g++) begin
      if ((g > int'(grp)) && grp_nz[g]) rest_zero = 1'b0;
    end
  end

  assign last_grp = (grp == GRP_W'(N - 1)) || rest_zero;
`else
  assign last_grp = (grp == GRP_W'(N - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grp         <= '0;
      acc         <= '0;
      sel_high_p0 <= 1'b0;
      product_r   <= '0;
      result_r    <= '0;
      for (int k = 0; k < NUM_PP; k++) pp_p0[k] <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        // Capture stage: operands are not looked at again after this edge.
        IDLE: begin
          if (bus.in_valid_i) begin
            for (int k = 0; k < NUM_PP; k++) pp_p0[k] <= bus.pp_flat_i[k*PP_W +: PP_W];
            sel_high_p0 <= bus.sel_high_i;
            acc         <= '0;
            grp         <= '0;
            state       <= ACCUM;
          end
        end
        // Accumulate stage: PPC weighted partials per edge.
        ACCUM: begin
          acc <= acc_next;
          grp <= grp + 1'b1;
          if (last_grp) begin
            product_r <= acc_next;
            result_r  <= sel_high_p0 ? acc_next[ACC_W-1:LENGTH] : acc_next[LENGTH-1:0];
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (state == IDLE) & ~rst;
  assign bus.out_valid_o = (state == DONE);
  assign bus.product_o   = product_r;
  assign bus.result_o    = result_r;

endmodule
